// File: rtl/game_state_fsm.sv
// Game phase sequencer: lives, level and frame-timed phases (invulnerability,
// level transition, game over) driven by hit / level-done / start events.
module game_state_fsm #(
  parameter int unsigned LIVES_INIT      = 3,
  parameter int unsigned INVULN_FRAMES   = 60,
  parameter int unsigned LEVELUP_FRAMES  = 45,
  parameter int unsigned GAMEOVER_FRAMES = 90,
  parameter int unsigned LEVELS          = 4
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       hitPulse,
  input  logic       startKey,
  input  logic       levelDone,
  output logic [2:0] gameState,
  output logic [2:0] lives,
  output logic [1:0] level,
  output logic       playEnable,
  output logic       invulnerable,
  output logic       blink,
  output logic       hitAccepted,
  output logic       gameOverPulse
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLAY      = 3'd1,
    S_INVULN    = 3'd2,
    S_LEVEL_UP  = 3'd3,
    S_GAME_OVER = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] lives_q, lives_d;
  logic [1:0] level_q, level_d;
  logic [7:0] cnt_q, cnt_d;
  logic       keyPrev_q;
  logic       hitAcc_q, hitAcc_d;
  logic       goPulse_q, goPulse_d;

  logic startRise, frameTick, expire;

  assign startRise = startKey & ~keyPrev_q;
  assign frameTick = startOfFrame && (cnt_q != 8'd0);
  assign expire    = startOfFrame && (cnt_q == 8'd1);

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    level_d   = level_q;
    cnt_d     = cnt_q;
    hitAcc_d  = 1'b0;
    goPulse_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (startRise) begin
          state_d = S_PLAY;
          lives_d = 3'(LIVES_INIT);
          level_d = 2'd0;
        end
      end
      S_PLAY: begin
        // A hit outranks levelDone; the load also swallows a coincident frame tick.
        if (hitPulse) begin
          hitAcc_d = 1'b1;
          if (lives_q != 3'd0) lives_d = lives_q - 3'd1;
          if (lives_q <= 3'd1) begin
            state_d   = S_GAME_OVER;
            cnt_d     = 8'(GAMEOVER_FRAMES);
            goPulse_d = 1'b1;
          end else begin
            state_d = S_INVULN;
            cnt_d   = 8'(INVULN_FRAMES);
          end
        end else if (levelDone) begin
          state_d = S_LEVEL_UP;
          cnt_d   = 8'(LEVELUP_FRAMES);
        end
      end
      S_INVULN: begin
        if (levelDone) begin
          state_d = S_LEVEL_UP;
          cnt_d   = 8'(LEVELUP_FRAMES);
        end else if (frameTick) begin
          cnt_d = cnt_q - 8'd1;
          if (expire) state_d = S_PLAY;
        end
      end
      S_LEVEL_UP: begin
        if (frameTick) begin
          cnt_d = cnt_q - 8'd1;
          if (expire) begin
            state_d = S_PLAY;
            level_d = (level_q == 2'(LEVELS - 1)) ? 2'd0 : level_q + 2'd1;
            lives_d = (lives_q == 3'd7) ? 3'd7 : lives_q + 3'd1;
          end
        end
      end
      S_GAME_OVER: begin
        if (frameTick) begin
          cnt_d = cnt_q - 8'd1;
          if (expire) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Key edge register resets high so a key held through reset cannot start a game.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= S_IDLE;
      lives_q   <= 3'(LIVES_INIT);
      level_q   <= 2'd0;
      cnt_q     <= 8'd0;
      keyPrev_q <= 1'b1;
      hitAcc_q  <= 1'b0;
      goPulse_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      keyPrev_q <= startKey;
      hitAcc_q  <= hitAcc_d;
      goPulse_q <= goPulse_d;
    end
  end

  assign gameState     = state_q;
  assign lives         = lives_q;
  assign level         = level_q;
  assign playEnable    = (state_q == S_PLAY) || (state_q == S_INVULN);
  assign invulnerable  = (state_q == S_INVULN) || (state_q == S_LEVEL_UP);
  assign blink         = (state_q == S_INVULN) && cnt_q[2];
  assign hitAccepted   = hitAcc_q;
  assign gameOverPulse = goPulse_q;

endmodule

// File: tb/tb_game_state_fsm.sv
// Directed bench for game_state_fsm: an event-level game model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_game_state_fsm;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame, hitPulse, startKey, levelDone;
  logic [2:0] gameState, lives;
  logic [1:0] level;
  logic       playEnable, invulnerable, blink, hitAccepted, gameOverPulse;

  int vecs = 0;
  int errs = 0;

  game_state_fsm dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .hitPulse(hitPulse),
    .startKey(startKey), .levelDone(levelDone), .gameState(gameState), .lives(lives),
    .level(level), .playEnable(playEnable), .invulnerable(invulnerable), .blink(blink),
    .hitAccepted(hitAccepted), .gameOverPulse(gameOverPulse)
  );

  always #5 clk = ~clk;

  // Game model: phase 0 idle, 1 play, 2 invuln, 3 level-up, 4 game over;
  // 'left' is frames still to be seen before the timed phase ends.
  int m_phase, m_lives, m_level, m_left;
  bit m_keyWas, m_hitAcc, m_goP;

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m_phase = 0; m_lives = 3; m_level = 0; m_left = 0;
      m_keyWas = 1; m_hitAcc = 0; m_goP = 0;
    end else begin
      bit rise;
      rise = startKey && !m_keyWas;
      m_keyWas = startKey;
      m_hitAcc = 0; m_goP = 0;
      if (m_phase == 0) begin
        if (rise) begin m_phase = 1; m_lives = 3; m_level = 0; end
      end else if (m_phase == 1) begin
        if (hitPulse) begin
          m_hitAcc = 1;
          m_lives = m_lives - 1;
          if (m_lives == 0) begin m_phase = 4; m_left = 90; m_goP = 1; end
          else begin m_phase = 2; m_left = 60; end
        end else if (levelDone) begin
          m_phase = 3; m_left = 45;
        end
      end else if (m_phase == 2 && levelDone) begin
        m_phase = 3; m_left = 45;
      end else if (startOfFrame && m_left > 0) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          if (m_phase == 3) begin
            m_level = (m_level + 1) % 4;
            m_lives = (m_lives >= 7) ? 7 : m_lives + 1;
          end
          m_phase = (m_phase == 4) ? 0 : 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_state", int'(gameState), m_phase);
    chk("cyc_lives", int'(lives), m_lives);
    chk("cyc_level", int'(level), m_level);
    chk("cyc_playEnable", int'(playEnable), int'(m_phase == 1 || m_phase == 2));
    chk("cyc_invulnerable", int'(invulnerable), int'(m_phase == 2 || m_phase == 3));
    chk("cyc_blink", int'(blink), (m_phase == 2) ? int'(m_left[2]) : 0);
    chk("cyc_hitAccepted", int'(hitAccepted), int'(m_hitAcc));
    chk("cyc_gameOverPulse", int'(gameOverPulse), int'(m_goP));
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse(input logic h, input logic d, input logic s);
    hitPulse = h; levelDone = d; startOfFrame = s;
    @(posedge clk); #1;
    hitPulse = 0; levelDone = 0; startOfFrame = 0;
  endtask

  task automatic frames(input int n);
    repeat (n) begin pulse(0, 0, 1); idle(2); end
  endtask

  task automatic keyEdge();
    startKey = 0; idle(1); startKey = 1; idle(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetN = 0; startKey = 1; hitPulse = 0; levelDone = 0; startOfFrame = 0;
    #23 resetN = 1;
    @(posedge clk); #1;
    idle(3);
    chk("held_key_stays_idle", int'(gameState), 0);
    chk("reset_lives", int'(lives), 3);

    keyEdge();
    chk("start_state", int'(gameState), 1);
    chk("start_lives", int'(lives), 3);
    chk("start_playEnable", int'(playEnable), 1);

    // Hit with a coincident frame tick: the tick is consumed by the load.
    pulse(1, 0, 1);
    chk("hit_state", int'(gameState), 2);
    chk("hit_lives", int'(lives), 2);
    chk("hit_accepted", int'(hitAccepted), 1);
    idle(1);
    chk("hit_accepted_one_cycle", int'(hitAccepted), 0);
    pulse(1, 0, 0);
    chk("invuln_hit_ignored", int'(lives), 2);
    frames(59);
    chk("invuln_59_frames", int'(gameState), 2);
    frames(1);
    chk("invuln_60_frames", int'(gameState), 1);

    pulse(1, 1, 0);
    chk("hit_beats_done_state", int'(gameState), 2);
    chk("hit_beats_done_level", int'(level), 0);
    pulse(0, 1, 0);
    chk("levelup_state", int'(gameState), 3);
    chk("levelup_invuln", int'(invulnerable), 1);
    chk("levelup_playEnable", int'(playEnable), 0);
    frames(44);
    chk("levelup_44_frames", int'(gameState), 3);
    frames(1);
    chk("levelup_done_state", int'(gameState), 1);
    chk("levelup_done_level", int'(level), 1);
    chk("levelup_done_lives", int'(lives), 2);

    for (int k = 0; k < 6; k++) begin
      pulse(0, 1, 0);
      frames(45);
      chk("wrap_level", int'(level), (k + 2) % 4);
      chk("sat_lives", int'(lives), (k + 3 > 7) ? 7 : k + 3);
    end

    // Reset asynchronously, mid-cycle, halfway through invulnerability.
    pulse(1, 0, 0);
    frames(30);
    @(posedge clk); #3;
    resetN = 0; #1;
    chk("rst_state", int'(gameState), 0);
    chk("rst_lives", int'(lives), 3);
    chk("rst_level", int'(level), 0);
    chk("rst_blink", int'(blink), 0);
    chk("rst_invuln", int'(invulnerable), 0);
    @(negedge clk); resetN = 1;
    @(posedge clk); #1;
    idle(3);
    chk("rst_stays_idle", int'(gameState), 0);
    keyEdge();
    chk("restart_state", int'(gameState), 1);

    pulse(1, 0, 0); frames(60);
    pulse(1, 0, 0); frames(60);
    chk("one_life_left", int'(lives), 1);
    pulse(1, 0, 0);
    chk("fatal_state", int'(gameState), 4);
    chk("fatal_lives", int'(lives), 0);
    chk("fatal_goPulse", int'(gameOverPulse), 1);
    idle(1);
    chk("fatal_goPulse_one_cycle", int'(gameOverPulse), 0);
    keyEdge();
    chk("gameover_key_ignored", int'(gameState), 4);
    frames(89);
    chk("gameover_89_frames", int'(gameState), 4);
    frames(1);
    chk("gameover_done_state", int'(gameState), 0);
    chk("gameover_done_lives", int'(lives), 0);
    pulse(1, 1, 1);
    chk("idle_ignores_events", int'(gameState), 0);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/game_state_fsm.md
# game_state_fsm

Top-level game sequencer that consumes the one-per-frame hit pulse from the collision detector and the level-complete event. It manages lives, level number and the game phase: idle, play, post-hit invulnerability, level transition and game over. It drives the play-enable and invulnerability controls that the object movement and drawing blocks consume. All timed phases are counted in frames using the start-of-frame pulse.

## Interface
- LIVES_INIT, 3: lives loaded at game start; legal range 1..7.
- INVULN_FRAMES, 60: frames of invulnerability after a non-fatal hit; legal range 1..255.
- LEVELUP_FRAMES, 45: frames of frozen play between levels; legal range 1..255.
- GAMEOVER_FRAMES, 90: frames the game-over screen is held; legal range 1..255.
- LEVELS, 4: number of levels; legal range 1..4.

Ports:
- clk, in, 1: system clock. This is the only clock.
- resetN, in, 1: asynchronous, active-low reset.
- startOfFrame, in, 1: one-cycle pulse at the start of each frame.
- hitPulse, in, 1: one-cycle collision pulse, at most one per frame.
- startKey, in, 1: level-sensitive start button. Its rising edge is detected internally.
- levelDone, in, 1: one-cycle pulse when the current level is cleared.
- gameState, out, 3: current state. IDLE=0, PLAY=1, INVULN=2, LEVEL_UP=3, GAME_OVER=4.
- lives, out, 3: remaining lives.
- level, out, 2: current level index, 0..LEVELS-1.
- playEnable, out, 1: high in PLAY and INVULN.
- invulnerable, out, 1: high in INVULN and LEVEL_UP.
- blink, out, 1: equals frameCnt[2] in INVULN, 0 otherwise. Used for sprite flicker.
- hitAccepted, out, 1: one-cycle pulse when a hit costs a life.
- gameOverPulse, out, 1: one-cycle pulse on entry to GAME_OVER.

## Operation
- Reset values:
  - state = IDLE, lives = LIVES_INIT, level = 0, frameCnt = 0.
  - All pulse outputs = 0.
  - The startKey edge register resets to 1, so a key held through reset does not start a game.
- startRise = startKey & ~startKeyPrev. startKeyPrev updates every cycle.
- IDLE:
  - On startRise, go to PLAY and reload lives = LIVES_INIT, level = 0.
  - hitPulse and levelDone are ignored.
- PLAY:
  - On hitPulse, pulse hitAccepted and decrement lives.
    - If lives was 1: lives becomes 0, go to GAME_OVER, frameCnt = GAMEOVER_FRAMES, pulse gameOverPulse.
    - Otherwise: go to INVULN, frameCnt = INVULN_FRAMES.
  - Else on levelDone: go to LEVEL_UP, frameCnt = LEVELUP_FRAMES.
  - If hitPulse and levelDone arrive in the same cycle, the hit wins and levelDone is dropped.
- INVULN:
  - hitPulse is ignored; no lives change and no hitAccepted.
  - levelDone goes to LEVEL_UP with frameCnt = LEVELUP_FRAMES.
  - When the frame count expires, go to PLAY.
- LEVEL_UP:
  - hitPulse and levelDone are ignored.
  - On expiry, level becomes (level+1) mod LEVELS, lives increments saturating at 7, and the state goes to PLAY.
- GAME_OVER:
  - All inputs, including startKey, are ignored.
  - On expiry, go to IDLE. lives stays 0 until the next start.
- Frame counting:
  - frameCnt is 8 bits. It is loaded on state entry.
  - Each startOfFrame in a timed state decrements it.
  - A startOfFrame with frameCnt == 1 triggers the exit transition, and frameCnt becomes 0.
  - A timed state therefore lasts exactly N startOfFrame pulses after the entry cycle.
  - A startOfFrame in the entry cycle itself is not counted, because the load takes priority.
- Lives and level arithmetic is unsigned. A decrement is applied only when lives ≥ 1.
- Asserting reset mid-operation returns immediately to the reset values, asynchronously.

## Timing
- All outputs are registered. They reflect an input event on the clock edge after the input cycle, which is 1-cycle latency.
- hitAccepted and gameOverPulse are high for exactly one cycle, coincident with the state change they accompany.
- playEnable, invulnerable and blink are decoded from registered state and frameCnt, with no extra latency.
- A hitPulse arriving in the same cycle as the INVULN→PLAY exit is ignored, because the state is still INVULN in that cycle.
- A startOfFrame coinciding with hitPulse in PLAY is consumed by the load and not counted.
- There is no back-pressure and no handshake. Every event pulse is sampled once and either acted on or dropped.

## Test plan
- Start game: reset, hold startKey high across reset release → stays IDLE. Toggle startKey 0→1 → next cycle gameState=1, lives=3, level=0, playEnable=1.
- Non-fatal hit: in PLAY, pulse hitPulse → hitAccepted for 1 cycle, lives=2, gameState=2. Extra hitPulse during INVULN → lives unchanged. Exactly 60 startOfFrame pulses later, gameState=1.
- Fatal hit: with lives=1, hit → lives=0, gameState=4, gameOverPulse for 1 cycle. A startKey edge during GAME_OVER is ignored. After 90 frames, gameState=0.
- Level up: levelDone in PLAY → gameState=3, invulnerable=1, playEnable=0. After 45 frames, level=1, lives+1, gameState=1. With LEVELS=4, level 3 wraps to 0. Lives saturate at 7.
- Simultaneous events:
  - hitPulse and levelDone in the same cycle in PLAY → INVULN, level unchanged.
  - startOfFrame in the entry cycle → still 60 further frames counted.
- Reset mid-INVULN with frameCnt=30 → all outputs return to reset values immediately. Only a new startKey edge restarts the game.
